// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: operand-forward
// selects, mul/div stall FSM states and stall-counter sizing.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int NUM_OPS  = 2;   // EX operands A and B
    localparam int MD_CNT_W = 4;
    localparam int PERF_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    function automatic logic [MD_CNT_W-1:0] md_load(input int lat);
        return MD_CNT_W'(lat - 2);
    endfunction

endpackage

// File: rtl/muldiv_stall_fsm.sv
// Holds the pipeline while a multi-cycle mul/div occupies EX:
// MULDIV_LAT stall cycles, then a single result-valid (done) cycle.
module muldiv_stall_fsm
    import hazard_pkg::*;
#(
    parameter int MULDIV_LAT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic MulDivE,
    output logic mdStall,
    output logic MulDivDoneE
);

    localparam logic [MD_CNT_W-1:0] CNT_LOAD = md_load(MULDIV_LAT);

    md_state_t             state, state_nxt;
    logic [MD_CNT_W-1:0]   cnt, cnt_nxt;
    logic                  stall_raw, done_raw;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The IDLE cycle that accepts the op already stalls, so BUSY lasts LAT-1 cycles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_raw = 1'b0;
        done_raw  = 1'b0;
        case (state)
            IDLE: begin
                if (MulDivE) begin
                    stall_raw = 1'b1;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                stall_raw = 1'b1;
                if (cnt == '0) state_nxt = DONE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            DONE: begin
                done_raw  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // IDLE decodes MulDivE combinationally, so mask it while reset is held.
    assign mdStall     = stall_raw & reset_n;
    assign MulDivDoneE = done_raw  & reset_n;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: EX forwarding, load-use stall, branch flush and
// mul/div hold. Define HAZARD_PERF_EN to build the stall/flush counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MULDIV_LAT = 4,
    parameter int REG_AW     = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              LoadE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              PCSrcE,
    input  logic              MulDivE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              MulDivDoneE,
    output logic [31:0]       StallCount,
    output logic [31:0]       FlushCount
);

    logic [NUM_OPS-1:0][REG_AW-1:0] rs_e;
    logic [NUM_OPS-1:0][1:0]        fwd;
    logic                           lw_stall, md_stall;

    assign rs_e = {Rs2E, Rs1E};

    // M has the younger result, so it wins over W; x0 never forwards.
    for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
        assign fwd[g] = (RegWriteM && RdM == rs_e[g] && rs_e[g] != '0) ? FWD_M :
                        (RegWriteW && RdW == rs_e[g] && rs_e[g] != '0) ? FWD_W :
                                                                         FWD_RF;
    end

    assign ForwardAE = reset_n ? fwd[0] : FWD_RF;
    assign ForwardBE = reset_n ? fwd[1] : FWD_RF;

    assign lw_stall = reset_n & LoadE & (RdE != '0) & ((Rs1D == RdE) | (Rs2D == RdE));

    muldiv_stall_fsm #(
        .MULDIV_LAT (MULDIV_LAT)
    ) u_md_fsm (
        .clk         (clk),
        .reset_n     (reset_n),
        .MulDivE     (MulDivE),
        .mdStall     (md_stall),
        .MulDivDoneE (MulDivDoneE)
    );

    // EX is frozen during a mul/div, so load-use and branch clears must not fire.
    assign StallF = lw_stall | md_stall;
    assign StallD = lw_stall | md_stall;
    assign StallE = md_stall;
    assign FlushM = md_stall;
    assign FlushD = reset_n & PCSrcE & ~md_stall;
    assign FlushE = (lw_stall | (reset_n & PCSrcE)) & ~md_stall;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (StallF && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (FlushE && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign StallCount = stall_cnt;
    assign FlushCount = flush_cnt;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed literal scenarios, then
// randomized traffic compared every cycle against a behavioural model.
module tb_hazard_unit;

    localparam int LAT = 4;
    localparam int AW  = 5;

    logic          clk, reset_n;
    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          LoadE, RegWriteM, RegWriteW, PCSrcE, MulDivE;
    logic          StallF, StallD, StallE, FlushD, FlushE, FlushM, MulDivDoneE;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [31:0]   StallCount, FlushCount;

    hazard_unit #(.MULDIV_LAT(LAT), .REG_AW(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .LoadE(LoadE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MulDivE(MulDivE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MulDivDoneE(MulDivDoneE), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase = cycles since the current mul/div entered EX (-1 when none).
    int          phase;
    logic [31:0] m_scnt, m_fcnt;
    logic        e_md, e_done, e_lw, e_br, e_stf, e_fle;
    logic [1:0]  e_fa, e_fb;

    function automatic logic [1:0] fwd_exp(input logic [AW-1:0] rs, input logic [AW-1:0] rdm,
                                           input logic wm, input logic [AW-1:0] rdw, input logic ww);
        if (rs == 0)               return 2'b00;
        if (wm && rdm == rs)       return 2'b10;
        if (ww && rdw == rs)       return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        e_md   = reset_n && ((phase < 0 && MulDivE) || (phase >= 0 && phase < LAT));
        e_done = reset_n && (phase == LAT);
        e_lw   = reset_n && LoadE && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
        e_br   = reset_n && PCSrcE;
        e_stf  = e_lw || e_md;
        e_fle  = (e_lw || e_br) && !e_md;
        e_fa   = reset_n ? fwd_exp(Rs1E, RdM, RegWriteM, RdW, RegWriteW) : 2'b00;
        e_fb   = reset_n ? fwd_exp(Rs2E, RdM, RegWriteM, RdW, RegWriteW) : 2'b00;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase  = -1;
            m_scnt = 0;
            m_fcnt = 0;
        end else begin
            if (e_stf && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
            if (e_fle && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
            if (phase < 0)        phase = MulDivE ? 1 : -1;
            else if (phase < LAT) phase = phase + 1;
            else                  phase = -1;   // done cycle ignores MulDivE
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("StallF", StallF, e_stf);
            chk("StallD", StallD, e_stf);
            chk("StallE", StallE, e_md);
            chk("FlushM", FlushM, e_md);
            chk("FlushD", FlushD, e_br && !e_md);
            chk("FlushE", FlushE, e_fle);
            chk("ForwardAE", ForwardAE, e_fa);
            chk("ForwardBE", ForwardBE, e_fb);
            chk("MulDivDoneE", MulDivDoneE, e_done);
`ifdef HAZARD_PERF_EN
            chk("StallCount", StallCount, m_scnt);
            chk("FlushCount", FlushCount, m_fcnt);
`else
            chk("StallCount", StallCount, 32'd0);
            chk("FlushCount", FlushCount, 32'd0);
`endif
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {LoadE, RegWriteM, RegWriteW, PCSrcE, MulDivE} = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        reset_n = 1'b0;
        MulDivE = 1'b1; PCSrcE = 1'b1; LoadE = 1'b1; RdE = 3; Rs1D = 3;
        Rs1E = 5; RdM = 5; RegWriteM = 1'b1;
        @(negedge clk);
        chk("rst_StallF", StallF, 0);
        chk("rst_StallE", StallE, 0);
        chk("rst_FlushD", FlushD, 0);
        chk("rst_FlushE", FlushE, 0);
        chk("rst_FwdA", ForwardAE, 2'b00);
        chk("rst_Done", MulDivDoneE, 0);
        chk("rst_SCnt", StallCount, 0);
        idle_inputs();
        nxt();
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // forwarding priority
        Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        @(negedge clk); chk("fwd_M", ForwardAE, 2'b10);
        nxt(); RegWriteM = 0;
        @(negedge clk); chk("fwd_W", ForwardAE, 2'b01);
        nxt(); Rs1E = 0;
        @(negedge clk); chk("fwd_x0", ForwardAE, 2'b00);
        nxt(); Rs2E = 5; RegWriteM = 1; RdM = 5;
        @(negedge clk); chk("fwdB_M", ForwardBE, 2'b10);

        // load-use
        nxt(); idle_inputs(); LoadE = 1; RdE = 3; Rs2D = 3;
        @(negedge clk);
        chk("lu_StallF", StallF, 1); chk("lu_StallD", StallD, 1);
        chk("lu_FlushE", FlushE, 1); chk("lu_StallE", StallE, 0);
        nxt(); LoadE = 0;
        @(negedge clk);
        chk("lu_clr_StallF", StallF, 0); chk("lu_clr_FlushE", FlushE, 0);

        // branch flush
        nxt(); PCSrcE = 1;
        @(negedge clk);
        chk("br_FlushD", FlushD, 1); chk("br_FlushE", FlushE, 1); chk("br_StallF", StallF, 0);
        nxt(); PCSrcE = 0;

        // mul/div from a fresh reset, with a load-use hazard inside the stall
        reset_n = 0;
        nxt(); reset_n = 1;
        nxt(); MulDivE = 1;
        for (int k = 0; k < LAT; k++) begin
            if (k == 1) begin LoadE = 1; RdE = 3; Rs2D = 3; end
            if (k == 2) LoadE = 0;
            @(negedge clk);
            chk("md_StallF", StallF, 1); chk("md_StallE", StallE, 1);
            chk("md_FlushM", FlushM, 1); chk("md_Done", MulDivDoneE, 0);
            if (k == 1) chk("md_lu_FlushE", FlushE, 0);
            nxt();
        end
        @(negedge clk);
        chk("md_Done_hi", MulDivDoneE, 1); chk("md_done_StallF", StallF, 0);
        nxt(); MulDivE = 0;
        @(negedge clk);
        chk("md_Done_lo", MulDivDoneE, 0);
`ifdef HAZARD_PERF_EN
        chk("perf_StallCount", StallCount, 32'd4);
        chk("perf_FlushCount", FlushCount, 32'd0);
`endif

        // reset mid-op, then restart on release
        nxt(); MulDivE = 1;
        nxt();
        nxt(); reset_n = 0;
        #1;
        chk("rmid_StallF", StallF, 0); chk("rmid_StallE", StallE, 0);
        nxt(); reset_n = 1;
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk); chk("rst_md_StallE", StallE, 1);
            nxt();
        end
        @(negedge clk); chk("rst_md_Done", MulDivDoneE, 1);
        nxt(); MulDivE = 0;

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            nxt();
            Rs1D = AW'($urandom_range(0, 3)); Rs2D = AW'($urandom_range(0, 3));
            Rs1E = AW'($urandom_range(0, 3)); Rs2E = AW'($urandom_range(0, 3));
            RdE  = AW'($urandom_range(0, 3)); RdM  = AW'($urandom_range(0, 3));
            RdW  = AW'($urandom_range(0, 3));
            LoadE     = ($urandom_range(0, 3) == 0);
            RegWriteM = $urandom_range(0, 1);
            RegWriteW = $urandom_range(0, 1);
            PCSrcE    = ($urandom_range(0, 5) == 0);
            MulDivE   = ($urandom_range(0, 5) == 0);
            if (!reset_n)                          reset_n = 1;
            else if ($urandom_range(0, 149) == 0)  reset_n = 0;
        end
        nxt();
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage pipelined processor. It generates the stall, clear and forwarding controls that the F/D/E/M pipeline registers and the EX-stage operand muxes consume. It combines combinational load-use, branch-flush and forwarding logic with a sequential stall FSM that holds the pipeline for multi-cycle multiply/divide operations in EX. It sits beside the datapath and drives every pipeline register's `clear`/enable input.

## Interface
Parameters:
- `MULDIV_LAT`, 4, stall cycles per multi-cycle EX op; legal range 2..15
- `REG_AW`, 5, register-index width

Ports:
- `clk`  in  1  pipeline clock
- `reset_n`  in  1  asynchronous, active-low reset
- `Rs1D`, `Rs2D`  in  REG_AW  source registers in Decode
- `Rs1E`, `Rs2E`, `RdE`  in  REG_AW  source and destination registers in Execute
- `RdM`, `RdW`  in  REG_AW  destination registers in Memory and Writeback
- `LoadE`  in  1  instruction in E is a load
- `RegWriteM`, `RegWriteW`  in  1  register-write enables in M and W
- `PCSrcE`  in  1  taken branch or jump resolved in E
- `MulDivE`  in  1  instruction in E is a multi-cycle mul/div
- `StallF`, `StallD`, `StallE`  out  1  hold the F, D and E registers
- `FlushD`, `FlushE`, `FlushM`  out  1  clear the D, E and M registers
- `ForwardAE`, `ForwardBE`  out  2  operand select: 00 register file, 01 W result, 10 M ALU result
- `MulDivDoneE`  out  1  final cycle of a mul/div in E; result valid
- `StallCount`, `FlushCount`  out  32  performance counters

## Operation
- Reset is asynchronous and active-low. One clock domain, `clk`.
- **Forwarding (A; B identical using `Rs2E`):**
  - 10 if `RegWriteM`, `RdM==Rs1E` and `Rs1E!=0`.
  - Otherwise 01 if `RegWriteW`, `RdW==Rs1E` and `Rs1E!=0`.
  - Otherwise 00.
- **Load-use stall:** `lwStall = LoadE & RdE!=0 & (Rs1D==RdE | Rs2D==RdE)`.
- **Mul/div FSM states:** IDLE, BUSY, DONE. A 4-bit down-counter `cnt` tracks BUSY.
  - IDLE & `MulDivE`: `mdStall=1`; load `cnt=MULDIV_LAT-2`; go to BUSY.
  - BUSY: `mdStall=1`. If `cnt==0`, go to DONE; otherwise decrement `cnt`.
  - DONE: `mdStall=0` and `MulDivDoneE=1`. `MulDivE` is ignored (same instruction still in E). Go to IDLE.
- **Output equations:**
  - `StallF = StallD = lwStall | mdStall`
  - `StallE = mdStall`
  - `FlushM = mdStall`
  - `FlushD = PCSrcE & ~mdStall`
  - `FlushE = (lwStall | PCSrcE) & ~mdStall`
- **Simultaneous events:** `mdStall` overrides load-use and branch flushes, because E is frozen. `PCSrcE` and `MulDivE` cannot be true for the same instruction; if both are asserted, `mdStall` wins.
- **Reset values:** FSM IDLE, `cnt=0`, both counters 0. While `reset_n` is low, all Stall/Flush outputs and `MulDivDoneE` are forced to 0 and `ForwardAE`/`ForwardBE` to 00.
- **Reset mid-op:** the FSM aborts to IDLE immediately. No DONE pulse is produced.

## Timing
- Forwarding, load-use and branch outputs are combinational: same cycle as their inputs.
- Mul/div op enters E at cycle t:
  - Stalls are high for cycles t..t+MULDIV_LAT-1.
  - `MulDivDoneE` is high at t+MULDIV_LAT.
  - The op moves to M at t+MULDIV_LAT+1.
  - Occupancy of E is MULDIV_LAT+1 cycles.
- Load-use costs exactly one bubble: the load advances and E is cleared in the following cycle.
- Back-to-back mul/div ops: the second op enters E after DONE. IDLE sees `MulDivE` again and restarts the FSM with no dead cycle.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `StallCount` increments every cycle `StallF=1`.
  - `FlushCount` increments every cycle `FlushE=1`.
  - Both saturate at 0xFFFF_FFFF and are cleared by reset.
- Undefined: both counters are not instantiated and the ports are tied to 0.

## Structure
- `hazard_pkg` holds:
  - forward-select constants `FWD_RF=2'b00`, `FWD_W=2'b01`, `FWD_M=2'b10`;
  - the FSM state enum `md_state_t` (IDLE, BUSY, DONE).
- One sub-module, `muldiv_stall_fsm`: inputs `clk`, `reset_n`, `MulDivE`; outputs `mdStall`, `MulDivDoneE`; parameter `MULDIV_LAT`.

## Test plan
- **Forwarding priority:** `Rs1E=5`, `RdM=5`, `RegWriteM=1`, `RdW=5`, `RegWriteW=1` -> `ForwardAE=10`. Set `RegWriteM=0` -> `ForwardAE=01`. Set `Rs1E=0` -> `ForwardAE=00`.
- **Load-use:** `LoadE=1`, `RdE=3`, `Rs2D=3` -> `StallF=StallD=FlushE=1` for one cycle. Next cycle with `LoadE=0` -> all 0.
- **Branch flush:** `PCSrcE=1` -> `FlushD=FlushE=1`, no stalls.
- **Mul/div, `MULDIV_LAT=4`:** `MulDivE` held from t -> StallF/D/E and FlushM high for t..t+3; `MulDivDoneE` high at t+4 only. A load-use condition raised during t+1 -> `FlushE` stays 0.
- **Reset mid-op:** `reset_n` low at t+2 -> all stalls 0 immediately. Release with `MulDivE=1` -> a fresh 4-cycle stall.
- **`HAZARD_PERF_EN`:** after the mul/div scenario -> `StallCount=4`. Preload the counter near saturation -> holds at 0xFFFF_FFFF.
